vram_responder: RTL and testbench

//  Memory-side end of the GPU request interface; it services requests issued by the port arbiter.

---
 rtl/vram_pkg.sv | 19 +
 rtl/vram_responder_rd_valid_pipe.sv | 36 +++
 rtl/vram_responder.sv | 163 ++++++++++++++++
 tb/tb_vram_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM responder: interface widths,
// out-of-range read data and the decoded request record.
package vram_pkg;

    localparam int         VRAM_ADDR_W     = 20;
    localparam int         VRAM_MEM_ADDR_W = 14;
    localparam int         MAX_RAM_LATENCY = 4;
    localparam logic [7:0] VRAM_OOR_DATA   = 8'hFF;

    // One sampled request from the arbiter, already decoded for range.
    typedef struct packed {
        logic                       rd;
        logic                       wr;
        logic                       oor;
        logic [VRAM_MEM_ADDR_W-1:0] addr;
        logic [7:0]                 data;
    } req_t;

endpackage

// File: rtl/vram_responder_rd_valid_pipe.sv
// Read tracking shift register: carries valid + out-of-range alongside the
// RAM access so the last stage lines up with ram_q and acts as the capture
// strobe for the output registers.
module rd_valid_pipe
    import vram_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    input  logic oor_i,
    output logic cap_valid_o,
    output logic cap_oor_o
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] oor_q;

    // Shift one stage per clock; a reset drops every read in flight.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its neighbour held before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            oor_q   <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-2:0], valid_i};
            oor_q   <= {oor_q[DEPTH-2:0], oor_i};
        end
    end

    assign cap_valid_o = valid_q[DEPTH-1];
    assign cap_oor_o   = oor_q[DEPTH-1];

endmodule

// File: rtl/vram_responder.sv
// Memory-side end of the GPU request interface. Issues byte reads/writes to
// a synchronous block RAM, resolves read/write collisions through a one-entry
// skid, and returns reads in order at a fixed latency. RAM_LATENCY is 1..4.
module vram_responder
    import vram_pkg::*;
#(
    parameter int         ADDR_W      = VRAM_ADDR_W,
    parameter int         MEM_ADDR_W  = VRAM_MEM_ADDR_W,
    parameter int         RAM_LATENCY = 2,
    parameter logic [7:0] OOR_DATA    = VRAM_OOR_DATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic                  wr_ena,
    input  logic [ADDR_W-1:0]     address,
    input  logic [7:0]            data_in,
    output logic                  rd_rdy,
    output logic [7:0]            data_out,
    output logic                  busy,
    output logic                  range_err,
    output logic                  proto_err,
    output logic [MEM_ADDR_W-1:0] ram_addr,
    output logic                  ram_wr_ena,
    output logic [7:0]            ram_data,
    input  logic [7:0]            ram_q
);

    req_t                  req;
    logic                  rd_accept;

    logic                  skid_valid_q, skid_valid_d;
    logic                  skid_oor_q, skid_oor_d;
    logic [MEM_ADDR_W-1:0] skid_addr_q, skid_addr_d;

    logic [MEM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_wr_q, ram_wr_d;
    logic [7:0]            ram_data_q, ram_data_d;

    logic                  range_err_q, range_err_d;
    logic                  proto_err_q, proto_err_d;

    logic                  issue_rd, issue_oor;
    logic                  cap_valid, cap_oor;
    logic                  rd_rdy_q;
    logic [7:0]            data_out_q;

    // Decode the incoming request; upper address bits only matter for range.
    always_comb begin
        req.rd   = rd_req;
        req.wr   = wr_ena;
        req.oor  = (address[ADDR_W-1:MEM_ADDR_W] != '0);
        req.addr = VRAM_MEM_ADDR_W'(address[MEM_ADDR_W-1:0]);
        req.data = data_in;
    end

    // A read is only accepted when the skid is free; otherwise it is dropped.
    assign rd_accept = req.rd && !skid_valid_q;

    // Issue arbitration: write first, then a pending skid read, then a new read.
    always_comb begin
        // NOTE: every comb output gets a default first, so no path can leave
        // a signal unassigned and infer a latch.
        skid_valid_d = skid_valid_q;
        skid_oor_d   = skid_oor_q;
        skid_addr_d  = skid_addr_q;
        ram_addr_d   = ram_addr_q;
        ram_wr_d     = 1'b0;
        ram_data_d   = ram_data_q;
        range_err_d  = range_err_q;
        proto_err_d  = proto_err_q;
        issue_rd     = 1'b0;
        issue_oor    = 1'b0;

        if (req.rd && skid_valid_q) begin
            proto_err_d = 1'b1;
        end
        if (rd_accept && req.oor) begin
            range_err_d = 1'b1;
        end

        if (req.wr) begin
            ram_addr_d = MEM_ADDR_W'(req.addr);
            ram_data_d = req.data;
            ram_wr_d   = !req.oor;
            if (req.oor) begin
                range_err_d = 1'b1;
            end
            // Colliding read waits one cycle behind the write.
            if (rd_accept) begin
                skid_valid_d = 1'b1;
                skid_oor_d   = req.oor;
                skid_addr_d  = MEM_ADDR_W'(req.addr);
            end
        end else if (skid_valid_q) begin
            ram_addr_d   = skid_addr_q;
            issue_rd     = 1'b1;
            issue_oor    = skid_oor_q;
            skid_valid_d = 1'b0;
        end else if (req.rd) begin
            ram_addr_d = MEM_ADDR_W'(req.addr);
            issue_rd   = 1'b1;
            issue_oor  = req.oor;
        end
    end

    // Issue-stage registers, skid entry and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_valid_q <= 1'b0;
            skid_oor_q   <= 1'b0;
            skid_addr_q  <= '0;
            ram_addr_q   <= '0;
            ram_wr_q     <= 1'b0;
            ram_data_q   <= '0;
            range_err_q  <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_oor_q   <= skid_oor_d;
            skid_addr_q  <= skid_addr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wr_q     <= ram_wr_d;
            ram_data_q   <= ram_data_d;
            range_err_q  <= range_err_d;
            proto_err_q  <= proto_err_d;
        end
    end

    rd_valid_pipe #(
        .DEPTH(RAM_LATENCY + 1)
    ) u_rd_valid_pipe (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (issue_rd),
        .oor_i      (issue_oor),
        .cap_valid_o(cap_valid),
        .cap_oor_o  (cap_oor)
    );

    // Output registers: capture ram_q (or the out-of-range pattern) on the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_rdy_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            rd_rdy_q <= cap_valid;
            if (cap_valid) begin
                data_out_q <= cap_oor ? OOR_DATA : ram_q;
            end
        end
    end

    assign rd_rdy     = rd_rdy_q;
    assign data_out   = data_out_q;
    assign busy       = skid_valid_q;
    assign range_err  = range_err_q;
    assign proto_err  = proto_err_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wr_ena = ram_wr_q;
    assign ram_data   = ram_data_q;

endmodule

// File: tb/tb_vram_responder.sv
// Bench for vram_responder: behavioural RAM with 2-cycle latency, a
// byte-array reference model, and a scoreboard monitor for reads and writes.
module tb_vram_responder;
    import vram_pkg::*;

    localparam int MEM_W = VRAM_MEM_ADDR_W;
    localparam int DEPTH = 1 << MEM_W;
    localparam int RD_LAT = 4;

    typedef struct {
        logic [7:0] data;
        int         due;
    } rd_exp_t;

    typedef struct {
        logic [MEM_W-1:0] addr;
        logic [7:0]       data;
        int               due;
    } wr_exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             rd_req = 1'b0;
    logic             wr_ena = 1'b0;
    logic [19:0]      address = '0;
    logic [7:0]       data_in = '0;
    logic             rd_rdy;
    logic [7:0]       data_out;
    logic             busy;
    logic             range_err;
    logic             proto_err;
    logic [MEM_W-1:0] ram_addr;
    logic             ram_wr_ena;
    logic [7:0]       ram_data;
    logic [7:0]       ram_q = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    rd_exp_t rq[$];
    wr_exp_t wq[$];
    rd_exp_t mon_re;
    wr_exp_t mon_we;

    logic [7:0] ref_mem [0:DEPTH-1];
    logic       m_busy = 1'b0;
    logic       m_skid_oor = 1'b0;
    int         m_skid_idx = 0;
    logic       m_range = 1'b0;
    logic       m_proto = 1'b0;

    vram_responder dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .wr_ena    (wr_ena),
        .address   (address),
        .data_in   (data_in),
        .rd_rdy    (rd_rdy),
        .data_out  (data_out),
        .busy      (busy),
        .range_err (range_err),
        .proto_err (proto_err),
        .ram_addr  (ram_addr),
        .ram_wr_ena(ram_wr_ena),
        .ram_data  (ram_data),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input int i);
        if (i < 4) return 8'(8'h10 + i);
        return 8'(i * 37 + 5);
    endfunction

    // Behavioural block RAM: old-data read-during-write, ram_q two clocks after ram_addr.
    logic [7:0] ram [0:DEPTH-1];
    logic [7:0] ram_q1 = '0;
    logic       init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
            init_done <= 1'b1;
        end else if (ram_wr_ena) begin
            ram[ram_addr] <= ram_data;
        end
        ram_q1 <= ram[ram_addr];
        ram_q  <= ram_q1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_read(input logic oor, input int idx, input int due);
        rd_exp_t e;
        e.data = oor ? VRAM_OOR_DATA : ref_mem[idx];
        e.due  = due;
        rq.push_back(e);
    endtask

    task automatic model_write(input logic oor, input int idx, input logic [7:0] d);
        wr_exp_t e;
        if (oor) begin
            m_range = 1'b1;
        end else begin
            ref_mem[idx] = d;
            e.addr = MEM_W'(idx);
            e.data = d;
            e.due  = cyc + 1;
            wq.push_back(e);
        end
    endtask

    // Reference behaviour for one sampled request in the current cycle.
    task automatic model_step(input logic rd, input logic wr, input logic [19:0] a, input logic [7:0] d);
        logic oor;
        int   idx;
        oor = (a[19:MEM_W] != '0);
        idx = int'(a[MEM_W-1:0]);
        if (m_busy) begin
            if (rd) m_proto = 1'b1;
            if (wr) begin
                model_write(oor, idx, d);
            end else begin
                push_read(m_skid_oor, m_skid_idx, cyc + RD_LAT);
                m_busy = 1'b0;
            end
        end else begin
            if (wr) model_write(oor, idx, d);
            if (rd) begin
                if (oor) m_range = 1'b1;
                if (wr) begin
                    m_busy     = 1'b1;
                    m_skid_oor = oor;
                    m_skid_idx = idx;
                end else begin
                    push_read(oor, idx, cyc + RD_LAT);
                end
            end
        end
    endtask

    // Present one cycle of stimulus; called #1 after a rising edge.
    task automatic drive(input logic rd, input logic wr, input logic [19:0] a, input logic [7:0] d);
        check("busy", 32'(busy), 32'(m_busy));
        rd_req  = rd;
        wr_ena  = wr;
        address = a;
        data_in = d;
        model_step(rd, wr, a, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idles(input int n);
        repeat (n) drive(1'b0, 1'b0, 20'h0, 8'h0);
    endtask

    task automatic check_flags();
        check("range_err", 32'(range_err), 32'(m_range));
        check("proto_err", 32'(proto_err), 32'(m_proto));
    endtask

    task automatic check_all_zero();
        check("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_range_err", 32'(range_err), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wr_ena", 32'(ram_wr_ena), 32'd0);
        check("rst_ram_data", 32'(ram_data), 32'd0);
    endtask

    task automatic pulse_reset();
        reset   = 1'b0;
        rd_req  = 1'b0;
        wr_ena  = 1'b0;
        address = '0;
        data_in = '0;
        rq.delete();
        wq.delete();
        m_busy  = 1'b0;
        m_range = 1'b0;
        m_proto = 1'b0;
        #1;
        check_all_zero();
        @(posedge clk);
        #1;
        check_all_zero();
        reset = 1'b1;
    endtask

    // Scoreboard monitor: compare every rd_rdy pulse and RAM write in order.
    always @(negedge clk) begin
        if (reset) begin
            if (rd_rdy) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected", 32'(rd_rdy), 32'd0);
                end else begin
                    mon_re = rq.pop_front();
                    check("rd_data", 32'(data_out), 32'(mon_re.data));
                    check("rd_cycle", 32'(cyc), 32'(mon_re.due));
                end
            end else if (rq.size() != 0 && rq[0].due < cyc) begin
                rq.delete(0);
                check("rd_missing", 32'(rd_rdy), 32'd1);
            end

            if (ram_wr_ena) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 32'(ram_wr_ena), 32'd0);
                end else begin
                    mon_we = wq.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(mon_we.addr));
                    check("wr_data", 32'(ram_data), 32'(mon_we.data));
                    check("wr_cycle", 32'(cyc), 32'(mon_we.due));
                end
            end else if (wq.size() != 0 && wq[0].due < cyc) begin
                wq.delete(0);
                check("wr_missing", 32'(ram_wr_ena), 32'd1);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero();
        reset = 1'b1;

        // Write then read the same byte two cycles later.
        drive(1'b0, 1'b1, 20'h00010, 8'hA5);
        idles(1);
        drive(1'b1, 1'b0, 20'h00010, 8'h00);
        idles(6);
        check_flags();

        // Back-to-back reads of preloaded bytes.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 20'(i), 8'h00);
        idles(6);

        // Collision: write first, skidded read returns the new byte.
        drive(1'b1, 1'b1, 20'h00005, 8'h3C);
        idles(7);
        check_flags();

        // Out-of-range write and read.
        drive(1'b0, 1'b1, 20'h04000, 8'h77);
        idles(1);
        drive(1'b1, 1'b0, 20'h04000, 8'h00);
        idles(6);
        check_flags();

        // Collision followed by a read while busy: second read dropped.
        drive(1'b1, 1'b1, 20'h00006, 8'h5A);
        drive(1'b1, 1'b0, 20'h00007, 8'h00);
        idles(7);
        check_flags();

        // Reset with two reads in flight, then a normal read.
        drive(1'b1, 1'b0, 20'h00001, 8'h00);
        drive(1'b1, 1'b0, 20'h00002, 8'h00);
        pulse_reset();
        drive(1'b1, 1'b0, 20'h00003, 8'h00);
        idles(6);
        check_flags();

        // Randomised traffic over a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            logic        r;
            logic        w;
            logic [19:0] a;
            logic [7:0]  d;
            r = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0)
                a = {6'($urandom_range(1, 63)), 14'($urandom_range(0, 7))};
            else
                a = 20'($urandom_range(0, 7));
            d = 8'($urandom);
            drive(r, w, a, d);
        end
        idles(10);
        check("rd_queue_drained", 32'(rq.size()), 32'd0);
        check("wr_queue_drained", 32'(wq.size()), 32'd0);
        check_flags();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
